// File: rtl/md_if.sv
// Handshake and data bundle between E-stage control and the multiply/divide unit.
interface md_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       md_op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] md_out;

  modport master (
    output start, md_op, rs, rt, flush,
    input  busy, done, hi, lo, md_out
  );

  modport slave (
    input  start, md_op, rs, rt, flush,
    output busy, done, hi, lo, md_out
  );
endinterface

// File: rtl/md_unit_param.sv
// Parametrised multi-cycle multiply/divide unit with HI/LO, multiply-accumulate
// and a flush that aborts an in-flight op without touching HI/LO.
module md_unit_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_r, state_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic [WIDTH-1:0] hi_r, hi_n, lo_r, lo_n;
  logic [WIDTH-1:0] sh_hi_r, sh_hi_n, sh_lo_r, sh_lo_n;
  logic             wr_r, wr_n;

  logic             is_mc_s, is_div_s, is_signed_s;
  logic [1:0]       acc_mode_s;
  logic [2*WIDTH-1:0] rs_ext_s, rt_ext_s, prod_s, mul_res_s;
  logic             rs_neg_s, rt_neg_s, div_zero_s;
  logic [WIDTH-1:0] rs_mag_s, rt_mag_s, rt_safe_s;
  logic [WIDTH-1:0] quo_mag_s, rem_mag_s, quo_s, rem_s;

  // Classify the op: multi-cycle, divide, signedness, accumulate direction.
  always_comb begin
    is_mc_s     = 1'b0;
    is_div_s    = 1'b0;
    is_signed_s = 1'b0;
    acc_mode_s  = 2'd0;
    case (bus.md_op)
      OP_MULT:  begin is_mc_s = 1'b1; is_signed_s = 1'b1; end
      OP_MULTU: begin is_mc_s = 1'b1; end
      OP_DIV:   begin is_mc_s = 1'b1; is_div_s = 1'b1; is_signed_s = 1'b1; end
      OP_DIVU:  begin is_mc_s = 1'b1; is_div_s = 1'b1; end
      OP_MADD:  begin is_mc_s = 1'b1; is_signed_s = 1'b1; acc_mode_s = 2'd1; end
      OP_MADDU: begin is_mc_s = 1'b1; acc_mode_s = 2'd1; end
      OP_MSUB:  begin is_mc_s = 1'b1; is_signed_s = 1'b1; acc_mode_s = 2'd2; end
      OP_MSUBU: begin is_mc_s = 1'b1; acc_mode_s = 2'd2; end
      default:  begin is_mc_s = 1'b0; end
    endcase
  end

  // Result datapath, evaluated at launch; signed divide works on magnitudes.
  always_comb begin
    rs_ext_s = is_signed_s ? {{WIDTH{bus.rs[WIDTH-1]}}, bus.rs} : {{WIDTH{1'b0}}, bus.rs};
    rt_ext_s = is_signed_s ? {{WIDTH{bus.rt[WIDTH-1]}}, bus.rt} : {{WIDTH{1'b0}}, bus.rt};
    prod_s   = rs_ext_s * rt_ext_s;
    case (acc_mode_s)
      2'd1:    mul_res_s = {hi_r, lo_r} + prod_s;
      2'd2:    mul_res_s = {hi_r, lo_r} - prod_s;
      default: mul_res_s = prod_s;
    endcase
    rs_neg_s   = is_signed_s & bus.rs[WIDTH-1];
    rt_neg_s   = is_signed_s & bus.rt[WIDTH-1];
    rs_mag_s   = rs_neg_s ? (~bus.rs + ONE_W) : bus.rs;
    rt_mag_s   = rt_neg_s ? (~bus.rt + ONE_W) : bus.rt;
    div_zero_s = (bus.rt == ZERO_W);
    rt_safe_s  = div_zero_s ? ONE_W : rt_mag_s;
    quo_mag_s  = rs_mag_s / rt_safe_s;
    rem_mag_s  = rs_mag_s % rt_safe_s;
    // Most-negative / -1 lands on 2^(WIDTH-1) naturally, which is the wanted LO.
    quo_s      = (rs_neg_s ^ rt_neg_s) ? (~quo_mag_s + ONE_W) : quo_mag_s;
    rem_s      = rs_neg_s ? (~rem_mag_s + ONE_W) : rem_mag_s;
  end

  // Next-state, counter, shadow capture and HI/LO commit.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    busy_n  = busy_r;
    done_n  = 1'b0;
    hi_n    = hi_r;
    lo_n    = lo_r;
    sh_hi_n = sh_hi_r;
    sh_lo_n = sh_lo_r;
    wr_n    = wr_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.flush && is_mc_s) begin
          state_n = ST_RUN;
          busy_n  = 1'b1;
          cnt_n   = is_div_s ? DIV_LOAD : MULT_LOAD;
          done_n  = ((is_div_s ? DIV_LOAD : MULT_LOAD) == CNT_ZERO);
          sh_hi_n = is_div_s ? rem_s : mul_res_s[2*WIDTH-1:WIDTH];
          sh_lo_n = is_div_s ? quo_s : mul_res_s[WIDTH-1:0];
          wr_n    = ~(is_div_s & div_zero_s);
        end else if (!bus.flush && bus.md_op == OP_MTHI) begin
          hi_n = bus.rs;
        end else if (!bus.flush && bus.md_op == OP_MTLO) begin
          lo_n = bus.rs;
        end else begin
          hi_n = hi_r;
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end else if (cnt_r == CNT_ZERO) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          if (wr_r) begin
            hi_n = sh_hi_r;
            lo_n = sh_lo_r;
          end else begin
            hi_n = hi_r;
          end
        end else begin
          cnt_n  = cnt_r - CNT_ONE;
          done_n = (cnt_r == CNT_ONE);
        end
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= ZERO_W;
      lo_r    <= ZERO_W;
      sh_hi_r <= ZERO_W;
      sh_lo_r <= ZERO_W;
      wr_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      hi_r    <= hi_n;
      lo_r    <= lo_n;
      sh_hi_r <= sh_hi_n;
      sh_lo_r <= sh_lo_n;
      wr_r    <= wr_n;
    end
  end

  // MFHI/MFLO read port.
  always_comb begin
    case (bus.md_op)
      OP_MFHI: bus.md_out = hi_r;
      OP_MFLO: bus.md_out = lo_r;
      default: bus.md_out = ZERO_W;
    endcase
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_md_unit_param.sv
// Bench for md_unit_param: a 32-bit default unit and a 16-bit single-cycle-multiply unit,
// both compared every cycle against a cycle-stamped arithmetic model.
module tb_md_unit_param;
  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  md_if #(.WIDTH(32)) bus_a ();
  md_if #(.WIDTH(16)) bus_b ();

  md_unit_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  md_unit_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state per unit: architectural HI/LO, pending result and last busy cycle.
  logic [31:0] m_hi [2] = '{32'd0, 32'd0};
  logic [31:0] m_lo [2] = '{32'd0, 32'd0};
  logic [31:0] m_rhi [2] = '{32'd0, 32'd0};
  logic [31:0] m_rlo [2] = '{32'd0, 32'd0};
  bit          m_wr [2] = '{1'b0, 1'b0};
  bit          m_act [2] = '{1'b0, 1'b0};
  int          m_end [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic void compute(input int w, input logic [3:0] op,
      input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] hi, input logic [31:0] lo,
      output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    logic [63:0] mw, m2, res;
    longint x, y, q, r;
    bit sgn;
    mw  = (64'd1 << w) - 64'd1;
    m2  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    sgn = (op == 4'd1) || (op == 4'd3) || (op == 4'd9) || (op == 4'd11);
    x = longint'({32'd0, rs});
    y = longint'({32'd0, rt});
    if (sgn && rs[w-1]) x = x - longint'(64'd1 << w);
    if (sgn && rt[w-1]) y = y - longint'(64'd1 << w);
    wr  = 1'b1;
    res = 64'd0;
    case (op)
      4'd1, 4'd2:   res = x * y;
      4'd9, 4'd10:  res = ((longint'({32'd0, hi}) << w) | longint'({32'd0, lo})) + x * y;
      4'd11, 4'd12: res = ((longint'({32'd0, hi}) << w) | longint'({32'd0, lo})) - x * y;
      4'd3, 4'd4: begin
        if (y == 0) wr = 1'b0;
        else begin
          q = x / y;
          r = x % y;
          res = ((r & mw) << w) | (q & mw);
        end
      end
      default: wr = 1'b0;
    endcase
    res = res & m2;
    rh  = 32'(res >> w);
    rl  = 32'(res & mw);
  endfunction

  task automatic model_step(input int u, input int w, input int nm, input int nd, input logic st,
      input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic fl);
    logic [31:0] rh, rl;
    bit wr;
    if (reset) begin
      m_hi[u] = 32'd0; m_lo[u] = 32'd0; m_act[u] = 1'b0;
    end else if (m_act[u]) begin
      if (fl) m_act[u] = 1'b0;
      else if (cyc == m_end[u] + 1) begin
        if (m_wr[u]) begin m_hi[u] = m_rhi[u]; m_lo[u] = m_rlo[u]; end
        m_act[u] = 1'b0;
      end
    end else if (!fl) begin
      if (st && ((op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12))) begin
        compute(w, op, rs, rt, m_hi[u], m_lo[u], rh, rl, wr);
        m_rhi[u] = rh; m_rlo[u] = rl; m_wr[u] = wr;
        m_act[u] = 1'b1;
        m_end[u] = cyc + (((op == 4'd3) || (op == 4'd4)) ? nd : nm) - 1;
      end else if (op == 4'd7) m_hi[u] = rs;
      else if (op == 4'd8) m_lo[u] = rs;
    end
  endtask

  function automatic logic [31:0] exp_out(input logic [3:0] op, input logic [31:0] hi, input logic [31:0] lo);
    return (op == 4'd5) ? hi : ((op == 4'd6) ? lo : 32'd0);
  endfunction

  // Model advances on each rising edge from the inputs held during the cycle just ended.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    model_step(0, 32, 5, 10, bus_a.start, bus_a.md_op, bus_a.rs, bus_a.rt, bus_a.flush);
    model_step(1, 16, 1, 3, bus_b.start, bus_b.md_op, {16'd0, bus_b.rs}, {16'd0, bus_b.rt}, bus_b.flush);
  end

  // Every-cycle comparison of both units against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("a_busy", {31'd0, bus_a.busy}, {31'd0, m_act[0]});
      chk("a_done", {31'd0, bus_a.done}, {31'd0, m_act[0] && (cyc == m_end[0])});
      chk("a_hi", bus_a.hi, m_hi[0]);
      chk("a_lo", bus_a.lo, m_lo[0]);
      chk("a_md_out", bus_a.md_out, exp_out(bus_a.md_op, m_hi[0], m_lo[0]));
      chk("b_busy", {31'd0, bus_b.busy}, {31'd0, m_act[1]});
      chk("b_done", {31'd0, bus_b.done}, {31'd0, m_act[1] && (cyc == m_end[1])});
      chk("b_hi", {16'd0, bus_b.hi}, m_hi[1]);
      chk("b_lo", {16'd0, bus_b.lo}, m_lo[1]);
      chk("b_md_out", {16'd0, bus_b.md_out}, exp_out(bus_b.md_op, m_hi[1], m_lo[1]));
    end
  end

  task automatic drive(input int u, input logic st, input logic [3:0] op,
      input logic [31:0] rs, input logic [31:0] rt, input logic fl);
    if (u == 0) begin
      bus_a.start = st; bus_a.md_op = op; bus_a.rs = rs; bus_a.rt = rt; bus_a.flush = fl;
    end else begin
      bus_b.start = st; bus_b.md_op = op; bus_b.rs = rs[15:0]; bus_b.rt = rt[15:0]; bus_b.flush = fl;
    end
  endtask

  // Returns 2 ns into the first busy cycle.
  task automatic issue(input int u, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk); #2;
    drive(u, 1'b1, op, rs, rt, 1'b0);
    @(posedge clk); #2;
    drive(u, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic mt(input int u, input logic [3:0] op, input logic [31:0] v, input logic fl);
    @(posedge clk); #2;
    drive(u, 1'b0, op, v, 32'd0, fl);
    @(posedge clk); #2;
    drive(u, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Counts busy cycles and done pulses until the unit is idle, with a cycle bound.
  task automatic wait_idle(input int u, output int nb, output int nd);
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((u == 0) ? bus_a.busy : bus_b.busy) nb++;
      if ((u == 0) ? bus_a.done : bus_b.done) nd++;
      if (!((u == 0) ? bus_a.busy : bus_b.busy)) break;
    end
  endtask

  initial begin
    int nb, nd;
    bit seen;
    reset = 1'b1;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, bus_a.busy}, 32'd0);
    chk("rst_hi", bus_a.hi, 32'd0);

    // Reset in the middle of a MULT clears HI and leaves no done.
    mt(0, 4'd7, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("mthi", bus_a.hi, 32'h1234_5678);
    issue(0, 4'd1, 32'd3, 32'd4);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, bus_a.busy}, 32'd0);
    chk("midrst_hi", bus_a.hi, 32'd0);
    chk("midrst_lo", bus_a.lo, 32'd0);
    repeat (6) @(negedge clk);

    issue(0, 4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(0, nb, nd);
    chk("mult_busy_cycles", nb, 32'd5);
    chk("mult_done_count", nd, 32'd1);
    chk("mult_hi", bus_a.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus_a.lo, 32'hFFFF_FFFA);
    chk("model_mult_lo", m_lo[0], 32'hFFFF_FFFA);

    issue(0, 4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(0, nb, nd);
    chk("div_busy_cycles", nb, 32'd10);
    chk("div_lo", bus_a.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus_a.hi, 32'hFFFF_FFFF);
    chk("model_div_hi", m_hi[0], 32'hFFFF_FFFF);

    issue(0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(0, nb, nd);
    chk("divovf_lo", bus_a.lo, 32'h8000_0000);
    chk("divovf_hi", bus_a.hi, 32'd0);
    chk("model_divovf_lo", m_lo[0], 32'h8000_0000);

    issue(0, 4'd4, 32'd5, 32'd0);
    wait_idle(0, nb, nd);
    chk("div0_busy_cycles", nb, 32'd10);
    chk("div0_done_count", nd, 32'd1);
    chk("div0_lo", bus_a.lo, 32'h8000_0000);
    chk("div0_hi", bus_a.hi, 32'd0);

    mt(0, 4'd8, 32'h0000_0055, 1'b1);
    @(negedge clk);
    chk("mtlo_flushed", bus_a.lo, 32'h8000_0000);

    mt(0, 4'd7, 32'd0, 1'b0);
    mt(0, 4'd8, 32'hFFFF_FFFF, 1'b0);
    issue(0, 4'd10, 32'd1, 32'd1);
    wait_idle(0, nb, nd);
    chk("maddu_busy_cycles", nb, 32'd5);
    chk("maddu_hi", bus_a.hi, 32'd1);
    chk("maddu_lo", bus_a.lo, 32'd0);
    chk("model_maddu_hi", m_hi[0], 32'd1);

    // MSUB flushed during its third busy cycle.
    issue(0, 4'd11, 32'd1, 32'd1);
    @(posedge clk); #2;
    @(posedge clk); #2 bus_a.flush = 1'b1;
    @(posedge clk); #2 bus_a.flush = 1'b0;
    wait_idle(0, nb, nd);
    chk("flush_busy_after", nb, 32'd0);
    repeat (5) begin
      @(negedge clk);
      if (bus_a.done) nd++;
    end
    chk("flush_done_count", nd, 32'd0);
    chk("flush_hi", bus_a.hi, 32'd1);
    chk("flush_lo", bus_a.lo, 32'd0);

    // Back-to-back: MSUBU launched in the cycle the MULT result becomes visible.
    issue(0, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus_a.done;
    end
    chk("b2b_done_seen", {31'd0, seen}, 32'd1);
    issue(0, 4'd12, 32'd2, 32'd3);
    wait_idle(0, nb, nd);
    chk("msubu_busy_cycles", nb, 32'd5);
    chk("msubu_hi", bus_a.hi, 32'hFFFF_FFFF);
    chk("msubu_lo", bus_a.lo, 32'hFFFF_FFFB);
    chk("model_msubu_lo", m_lo[0], 32'hFFFF_FFFB);

    // start with a single-cycle op launches nothing; MFLO reads LO.
    @(posedge clk); #2 drive(0, 1'b1, 4'd6, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    chk("mflo_out", bus_a.md_out, 32'hFFFF_FFFB);
    @(posedge clk); #2 drive(0, 1'b0, 4'd5, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("start_mf_busy", {31'd0, bus_a.busy}, 32'd0);
    chk("mfhi_out", bus_a.md_out, 32'hFFFF_FFFF);
    @(posedge clk); #2 drive(0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

    // 16-bit unit, single-cycle multiply; a start inside the busy cycle is dropped.
    issue(1, 4'd2, 32'h0000_FFFF, 32'h0000_FFFF);
    drive(1, 1'b1, 4'd2, 32'd2, 32'd2, 1'b0);
    @(negedge clk);
    chk("w16_busy", {31'd0, bus_b.busy}, 32'd1);
    chk("w16_done", {31'd0, bus_b.done}, 32'd1);
    @(posedge clk); #2 drive(1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("w16_busy_after", {31'd0, bus_b.busy}, 32'd0);
    chk("w16_hi", {16'd0, bus_b.hi}, 32'h0000_FFFE);
    chk("w16_lo", {16'd0, bus_b.lo}, 32'h0000_0001);
    chk("model_w16_hi", m_hi[1], 32'h0000_FFFE);
    repeat (3) @(negedge clk);
    chk("w16_ignored_hi", {16'd0, bus_b.hi}, 32'h0000_FFFE);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1);
  end
endmodule
